adpcm_enc_pack: RTL and testbench
=================================

ADPCM_ENC_PACK -- requirements
Module: adpcm_enc_pack

Interface
REQ-001 Parameter ACK_TMO, default 8: max cycles allowed from c_req toggle until c_ack falls.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rstn  input  1  reset; asynchronous, active-low.
REQ-004 enable  input  1  synchronous enable; 0 clears all state and outputs to reset values.
REQ-005 s_pcm  input  16  signed PCM sample, upstream side.
REQ-006 s_valid / s_ready  input / output  1 each  upstream sample handshake.
REQ-007 s_last  input  1  sample is the last of its block; qualified with s_valid.
REQ-008 c_rx_pcm  output  16  sample presented to the codec PCM input.
REQ-009 c_sel_rx  output  1  codec direction select; constant 0 (encode).
REQ-010 c_req  output  1  toggle-style codec request; each level change is one request.
REQ-011 c_ack  input  1  codec idle flag; high = idle.
REQ-012 c_tx_adpcm  input  4  codec nibble output; valid once c_ack returns high.
REQ-013 m_byte  output  8  packed ADPCM byte.
REQ-014 m_valid / m_ready  output / input  1 each  downstream byte handshake.
REQ-015 m_last  output  1  byte closes the block.
REQ-016 err_tmo  output  1  sticky flag: the codec did not respond in time.

Function
REQ-017 Transfers: s_valid&s_ready = one sample; m_valid&m_ready = one byte.
REQ-018 FSM states: IDLE, SETUP, FIRE, WAIT_LO, WAIT_HI, PACK, OUT.
REQ-019 IDLE: s_ready=1 only when c_ack=1 and m_valid=0; on transfer latch s_pcm into c_rx_pcm and s_last into a last flag -> SETUP.
REQ-020 SETUP: hold c_rx_pcm for one cycle so the codec samples it while idle -> FIRE.
REQ-021 FIRE: invert c_req, clear the timeout counter -> WAIT_LO.
REQ-022 WAIT_LO: c_ack=0 -> WAIT_HI; else increment the counter; at ACK_TMO set err_tmo and return to IDLE, dropping the sample and any held nibble.
REQ-023 WAIT_HI: c_ack=1 -> PACK; no timeout in this state.
REQ-024 PACK, nibble phase 0: store c_tx_adpcm as the low nibble and set phase=1; if last flag=1, also form the byte {4'h0, nibble} with m_last=1 -> OUT; otherwise -> IDLE.
REQ-025 PACK, phase 1: form the byte {c_tx_adpcm, held low nibble} with m_last=last flag, set phase=0 -> OUT.
REQ-026 OUT: m_valid=1; m_byte and m_last stay stable until m_ready=1; the accepting cycle clears m_valid, m_last and phase -> IDLE.
REQ-027 Backpressure: while m_valid=1, s_ready=0; no sample is dropped and no byte is overwritten.
REQ-028 Latency: from sample accept to c_req toggle is exactly 2 cycles.
REQ-029 Per-sample throughput: 2 cycles of setup plus codec latency (7 cycles after the ack falls) plus 1 PACK cycle.
REQ-030 c_rx_pcm passes through unmodified (no saturation or scaling); c_sel_rx=0 at all times.
REQ-031 err_tmo clears only on reset or when enable=0.
REQ-032 Simultaneous m_ready and a new s_valid in OUT: the byte is accepted and s_ready stays 0 that cycle; the sample is taken in IDLE on the next cycle.

Reset
REQ-033 While rstn=0 or enable=0, all outputs and state take their reset values:
  - c_req=0, c_rx_pcm=0, m_byte=0, m_valid=0, m_last=0, s_ready=0, err_tmo=0;
  - phase=0, FSM in IDLE.
REQ-034 Reset or disable mid-operation discards any in-flight sample and held nibble; after release, the first accepted sample is nibble phase 0.

Verification
REQ-035 Two samples, codec model returns nibbles 0x3 then 0xA, m_ready=1 -> one byte m_byte=0xA3, m_last=0, exactly two c_req toggles.
REQ-036 Three samples, the third with s_last=1, nibbles 1, 2, 7 -> bytes 0x21 (m_last=0) then 0x07 (m_last=1).
REQ-037 m_ready held 0 for 20 cycles with the next sample pending -> m_byte stable and s_ready=0 throughout; after release, the byte is accepted and the next sample is taken one cycle later.
REQ-038 Codec model holds c_ack=1 (never falls) -> err_tmo=1 ACK_TMO cycles after the c_req toggle; FSM back in IDLE; no byte emitted.
REQ-039 rstn asserted in WAIT_HI after the first nibble was held -> outputs at reset values; the next two samples (nibbles 4, 5) give byte 0x54.
REQ-040 Check c_rx_pcm=0x8000 and 0x7FFF pass through unchanged; c_rx_pcm is stable from SETUP through the c_req toggle.

Source files
------------

// File: rtl/adpcm_enc_pack.sv
// adpcm_enc_pack: hands signed PCM samples one at a time to a toggle-request
// ADPCM codec (encode direction), collects the 4-bit codes it returns and packs
// two consecutive codes into one byte, low nibble first, on a valid/ready stream.
// A block ending on an odd code is flushed as {4'h0, code} with m_last set.
module adpcm_enc_pack #(
  parameter int ACK_TMO = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [15:0] s_pcm,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  output logic [15:0] c_rx_pcm,
  output logic        c_sel_rx,
  output logic        c_req,
  input  logic        c_ack,
  input  logic [3:0]  c_tx_adpcm,
  output logic [7:0]  m_byte,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        err_tmo
);

  localparam int CNT_W = $clog2(ACK_TMO + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    FIRE    = 3'd2,
    WAIT_LO = 3'd3,
    WAIT_HI = 3'd4,
    PACK    = 3'd5,
    OUT     = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic signed [15:0] pcm_q, pcm_d;
  logic               last_q, last_d;
  logic               req_q, req_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               tmo_hit;
  logic               err_q, err_d;
  logic               phase_q, phase_d;
  logic [3:0]         nib_q, nib_d;
  logic [7:0]         byte_q, byte_d;
  logic               mvalid_q, mvalid_d;
  logic               mlast_q, mlast_d;
  // Keeps s_ready low while reset is asserted and for the first edge after it.
  logic               run_q, run_d;
  logic               accept;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign tmo_hit = (cnt_inc == CNT_W'(ACK_TMO));
  assign accept  = s_valid && s_ready;

  // Output process: the only combinational output is the upstream ready.
  always_comb begin
    s_ready = 1'b0;
    if (run_q && enable && (state_q == IDLE) && c_ack && !mvalid_q) begin
      s_ready = 1'b1;
    end
  end

  // Next-state process: one sample walks SETUP -> FIRE -> codec wait -> PACK.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = SETUP;
        SETUP:   state_d = FIRE;
        FIRE:    state_d = WAIT_LO;
        WAIT_LO: begin
          if (!c_ack) begin
            state_d = WAIT_HI;
          end else if (tmo_hit) begin
            state_d = IDLE;
          end
        end
        WAIT_HI: if (c_ack) state_d = PACK;
        PACK:    state_d = (!phase_q && !last_q) ? IDLE : OUT;
        OUT:     if (m_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath next values: sample latch, request toggle, timeout and nibble packing.
  always_comb begin
    pcm_d    = pcm_q;
    last_d   = last_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    phase_d  = phase_q;
    nib_d    = nib_q;
    byte_d   = byte_q;
    mvalid_d = mvalid_q;
    mlast_d  = mlast_q;
    run_d    = 1'b1;
    if (!enable) begin
      pcm_d    = '0;
      last_d   = 1'b0;
      req_d    = 1'b0;
      cnt_d    = '0;
      err_d    = 1'b0;
      phase_d  = 1'b0;
      nib_d    = '0;
      byte_d   = '0;
      mvalid_d = 1'b0;
      mlast_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            pcm_d  = s_pcm;
            last_d = s_last;
          end
        end
        FIRE: begin
          req_d = ~req_q;
          cnt_d = '0;
        end
        WAIT_LO: begin
          if (c_ack) begin
            cnt_d = cnt_inc;
            if (tmo_hit) begin
              // Codec never took the request: drop this sample and any half byte.
              err_d   = 1'b1;
              phase_d = 1'b0;
              nib_d   = '0;
            end
          end
        end
        PACK: begin
          if (!phase_q) begin
            nib_d   = c_tx_adpcm;
            phase_d = 1'b1;
            if (last_q) begin
              byte_d   = {4'h0, c_tx_adpcm};
              mlast_d  = 1'b1;
              mvalid_d = 1'b1;
            end
          end else begin
            byte_d   = {c_tx_adpcm, nib_q};
            mlast_d  = last_q;
            mvalid_d = 1'b1;
            phase_d  = 1'b0;
          end
        end
        OUT: begin
          if (m_ready) begin
            mvalid_d = 1'b0;
            mlast_d  = 1'b0;
            phase_d  = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pcm_q    <= '0;
      last_q   <= 1'b0;
      req_q    <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      phase_q  <= 1'b0;
      nib_q    <= '0;
      byte_q   <= '0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      pcm_q    <= pcm_d;
      last_q   <= last_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      phase_q  <= phase_d;
      nib_q    <= nib_d;
      byte_q   <= byte_d;
      mvalid_q <= mvalid_d;
      mlast_q  <= mlast_d;
      run_q    <= run_d;
    end
  end

  assign c_rx_pcm = pcm_q;
  assign c_sel_rx = 1'b0;
  assign c_req    = req_q;
  assign m_byte   = byte_q;
  assign m_valid  = mvalid_q;
  assign m_last   = mlast_q;
  assign err_tmo  = err_q;

endmodule

// File: tb/tb_adpcm_enc_pack.sv
// tb_adpcm_enc_pack: directed bench with a toggle-handshake codec model and a
// byte-stream model built from the packing rules (pairs of codes, low first;
// odd code at block end flushed alone with the last flag).
module tb_adpcm_enc_pack;
  localparam int ACK_TMO = 8;
  localparam int LAT     = 7;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [15:0] s_pcm;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [15:0] c_rx_pcm;
  logic        c_sel_rx;
  logic        c_req;
  logic        c_ack;
  logic [3:0]  c_tx_adpcm;
  logic [7:0]  m_byte;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        err_tmo;

  adpcm_enc_pack #(.ACK_TMO(ACK_TMO)) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .s_pcm(s_pcm), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .c_rx_pcm(c_rx_pcm), .c_sel_rx(c_sel_rx), .c_req(c_req), .c_ack(c_ack),
    .c_tx_adpcm(c_tx_adpcm),
    .m_byte(m_byte), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state
  logic [8:0]  exp_q[$];
  logic [8:0]  got_q[$];
  logic        inflight_q[$];
  logic [3:0]  nib_fifo[$];
  logic [15:0] tog_pcm_q[$];
  logic        pend_valid = 1'b0;
  logic [3:0]  pend_nib = 4'h0;
  logic        exp_err = 1'b0;
  int          busy = 0;
  int          tmo_cnt = 0;
  logic        req_prev = 1'b0;
  logic        codec_dead = 1'b0;
  int          toggles = 0;
  int          acc_cyc = 0;
  int          byte_acc_cyc = 0;
  logic [15:0] acc_pcm = 16'h0;
  logic        prev_hold = 1'b0;
  logic [8:0]  prev_out = 9'h0;
  logic [8:0]  exp_e;
  logic [3:0]  codec_n;
  logic        lf;
  int          g0;
  int          t0;
  int          wn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    inflight_q.delete();
    pend_valid = 1'b0;
    exp_err    = 1'b0;
    busy       = 0;
    tmo_cnt    = 0;
    req_prev   = 1'b0;
    c_ack      = 1'b1;
    c_tx_adpcm = 4'h0;
    prev_hold  = 1'b0;
  endtask

  // Expected byte stream from one returned code.
  task automatic model_nibble(input logic [3:0] n);
    lf = 1'b0;
    if (inflight_q.size() != 0) lf = inflight_q.pop_front();
    if (!pend_valid) begin
      if (lf) exp_q.push_back({1'b1, 4'h0, n});
      else begin
        pend_nib   = n;
        pend_valid = 1'b1;
      end
    end else begin
      exp_q.push_back({lf, n, pend_nib});
      pend_valid = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_c_req"},    32'(c_req),    32'h0);
    chk({p, "_c_rx_pcm"}, 32'(c_rx_pcm), 32'h0);
    chk({p, "_m_byte"},   32'(m_byte),   32'h0);
    chk({p, "_m_valid"},  32'(m_valid),  32'h0);
    chk({p, "_m_last"},   32'(m_last),   32'h0);
    chk({p, "_s_ready"},  32'(s_ready),  32'h0);
    chk({p, "_err_tmo"},  32'(err_tmo),  32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] pcm, input logic last);
    int n;
    s_pcm = pcm; s_last = last; s_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, required within 300", n);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_bytes(input int target);
    int n;
    n = 0;
    while (got_q.size() < target && n <= 300) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() < target) begin
      checks++; errors++;
      $display("FAIL byte_timeout: got %0d bytes, required %0d", got_q.size(), target);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_model();
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic do_disable();
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("dis");
    @(posedge clk); #1;
    enable = 1'b1;
    clear_model();
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process: checks outputs every cycle away from the clock edge.
  initial forever begin
    @(negedge clk);
    chk("sel_rx", 32'(c_sel_rx), 32'h0);
    if (rstn) begin
      if (enable) chk("err_tmo", 32'(err_tmo), 32'(exp_err));
      if (m_valid) chk("s_ready_bp", 32'(s_ready), 32'h0);
      if (prev_hold) chk("hold", 32'({m_last, m_byte}), 32'(prev_out));
      if (m_valid && m_ready) begin
        chk("byte_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          chk("byte", 32'({m_last, m_byte}), 32'(exp_e));
        end
        got_q.push_back({m_last, m_byte});
        byte_acc_cyc = cyc + 1;
      end
      prev_hold = m_valid && !m_ready && enable;
      prev_out  = {m_last, m_byte};
      if (s_valid && s_ready) begin
        inflight_q.push_back(s_last);
        acc_pcm = s_pcm;
        acc_cyc = cyc + 1;
      end
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Codec model: ack falls right after a request toggle, returns 7 cycles later.
  initial forever begin
    @(posedge clk); #2;
    if (rstn && enable) begin
      if (c_req !== req_prev) begin
        req_prev = c_req;
        toggles++;
        chk("req_latency", 32'(cyc - acc_cyc), 32'd2);
        chk("pcm_thru", 32'(c_rx_pcm), 32'(acc_pcm));
        tog_pcm_q.push_back(c_rx_pcm);
        if (codec_dead) tmo_cnt = ACK_TMO;
        else begin
          c_ack = 1'b0;
          busy  = LAT;
        end
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          codec_n = 4'h0;
          if (nib_fifo.size() != 0) codec_n = nib_fifo.pop_front();
          c_tx_adpcm = codec_n;
          c_ack = 1'b1;
          model_nibble(codec_n);
        end
      end else if (tmo_cnt > 0) begin
        tmo_cnt--;
        if (tmo_cnt == 0) begin
          exp_err = 1'b1;
          if (inflight_q.size() != 0) lf = inflight_q.pop_front();
          pend_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; enable = 1'b1; s_valid = 1'b0; s_pcm = 16'h0; s_last = 1'b0;
    m_ready = 1'b1;
    clear_model();
    @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(2);

    // Two samples -> one byte 0xA3
    nib_fifo.push_back(4'h3); nib_fifo.push_back(4'hA);
    t0 = toggles; g0 = got_q.size();
    send(16'h1234, 1'b0);
    send(16'h8000, 1'b0);
    wait_bytes(g0 + 1);
    chk("t1_byte", 32'(got_q[g0]), 32'h0A3);
    chk("t1_toggles", 32'(toggles - t0), 32'd2);
    chk("t1_pcm_8000", 32'(tog_pcm_q[tog_pcm_q.size() - 1]), 32'h8000);
    idle(2);

    // Three samples, last odd -> 0x21 then 0x07 with last
    nib_fifo.push_back(4'h1); nib_fifo.push_back(4'h2); nib_fifo.push_back(4'h7);
    g0 = got_q.size();
    send(16'h0100, 1'b0);
    send(16'h7FFF, 1'b0);
    send(16'hFFFF, 1'b1);
    wait_bytes(g0 + 2);
    chk("t2_byte0", 32'(got_q[g0]), 32'h021);
    chk("t2_byte1", 32'(got_q[g0 + 1]), 32'h107);
    chk("t2_pcm_7fff", 32'(tog_pcm_q[tog_pcm_q.size() - 2]), 32'h7FFF);
    idle(2);

    // Backpressure: byte 0x86 held 20 cycles with a sample pending
    nib_fifo.push_back(4'h6); nib_fifo.push_back(4'h8); nib_fifo.push_back(4'hC);
    g0 = got_q.size();
    m_ready = 1'b0;
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    fork
      send(16'h3333, 1'b1);
      begin
        wn = 0;
        while (!m_valid && wn < 300) begin
          idle(1);
          wn++;
        end
        chk("bp_valid_seen", 32'(m_valid), 32'h1);
        repeat (20) begin
          idle(1);
          chk("bp_s_ready", 32'(s_ready), 32'h0);
          chk("bp_byte", 32'(m_byte), 32'h86);
        end
        m_ready = 1'b1;
      end
    join
    chk("bp_next_sample", 32'(acc_cyc - byte_acc_cyc), 32'd1);
    wait_bytes(g0 + 2);
    chk("bp_byte0", 32'(got_q[g0]), 32'h086);
    chk("bp_byte1", 32'(got_q[g0 + 1]), 32'h10C);
    idle(2);

    // Codec never drops ack -> sticky timeout, no byte
    codec_dead = 1'b1;
    g0 = got_q.size();
    send(16'h4444, 1'b0);
    idle(ACK_TMO + 3);
    chk("tmo_err", 32'(err_tmo), 32'h1);
    chk("tmo_idle_ready", 32'(s_ready), 32'h1);
    chk("tmo_no_valid", 32'(m_valid), 32'h0);
    chk("tmo_no_byte", 32'(got_q.size()), 32'(g0));
    idle(5);
    chk("tmo_sticky", 32'(err_tmo), 32'h1);
    codec_dead = 1'b0;
    do_disable();
    idle(2);

    // Reset while in WAIT_HI with a nibble held -> next pair gives 0x54
    nib_fifo.push_back(4'h9); nib_fifo.push_back(4'h4); nib_fifo.push_back(4'h5);
    send(16'h0AAA, 1'b0);
    send(16'h0BBB, 1'b0);
    wn = 0;
    while (c_ack && wn < 300) begin
      idle(1);
      wn++;
    end
    chk("wait_hi_reached", 32'(c_ack), 32'h0);
    idle(2);
    do_reset();
    idle(1);
    g0 = got_q.size();
    send(16'h0CCC, 1'b0);
    send(16'h0DDD, 1'b0);
    wait_bytes(g0 + 1);
    chk("rst_byte", 32'(got_q[g0]), 32'h054);

    idle(3);
    chk("no_missing_bytes", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
